// File: rtl/carry_select_adder_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready on both sides.
// Stage 1 holds the per-block speculative sums; stage 2 resolves the carry-select chain.
module carry_select_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NBLK = WIDTH / BLK;

    // Handshake
    logic ready1;
    logic ready2;
    logic in_fire;

    // Stage-1 combinational results
    logic [WIDTH-1:0]             b_eff;
    logic                         c0;
    logic [BLK-1:0]               lo_sum_d;
    logic                         lo_c_d;
    logic [NBLK-1:1][BLK-1:0]     hi_sum0_d;
    logic [NBLK-1:1][BLK-1:0]     hi_sum1_d;
    logic [NBLK-1:1]              hi_c0_d;
    logic [NBLK-1:1]              hi_c1_d;

    // Stage-1 registers
    logic                         v1;
    logic [BLK-1:0]               lo_sum_q;
    logic                         lo_c_q;
    logic [NBLK-1:1][BLK-1:0]     hi_sum0_q;
    logic [NBLK-1:1][BLK-1:0]     hi_sum1_q;
    logic [NBLK-1:1]              hi_c0_q;
    logic [NBLK-1:1]              hi_c1_q;
    logic                         a_msb_q;
    logic                         b_msb_q;

    // Stage-2 combinational results
    logic [WIDTH-1:0]             sel_sum;
    logic                         carry;
    logic                         sel_ovf;

    assign ready2  = !OutValid || OutReady;
    assign ready1  = !v1 || ready2;
    assign InReady = ready1 && !rst;
    assign in_fire = InValid && InReady;

    // Subtraction is A + ~B + 1, so Cin is ignored in that mode.
    assign b_eff = Sub ? ~B : B;
    assign c0    = Sub ? 1'b1 : Cin;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        if (k == 0) begin : g_lo
            logic [BLK:0] r;
            assign r        = {1'b0, A[BLK-1:0]} + {1'b0, b_eff[BLK-1:0]} + {{BLK{1'b0}}, c0};
            assign lo_sum_d = r[BLK-1:0];
            assign lo_c_d   = r[BLK];
        end else begin : g_hi
            logic [BLK:0] r0;
            logic [BLK:0] r1;
            assign r0 = {1'b0, A[k*BLK +: BLK]} + {1'b0, b_eff[k*BLK +: BLK]};
            assign r1 = {1'b0, A[k*BLK +: BLK]} + {1'b0, b_eff[k*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
            assign hi_sum0_d[k] = r0[BLK-1:0];
            assign hi_c0_d[k]   = r0[BLK];
            assign hi_sum1_d[k] = r1[BLK-1:0];
            assign hi_c1_d[k]   = r1[BLK];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data registers are cleared too, not just the valid bit, so
            // the flop contents after reset are deterministic.
            v1        <= 1'b0;
            lo_sum_q  <= '0;
            lo_c_q    <= 1'b0;
            hi_sum0_q <= '0;
            hi_sum1_q <= '0;
            hi_c0_q   <= '0;
            hi_c1_q   <= '0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
        end else if (ready1) begin
            v1 <= in_fire;
            if (in_fire) begin
                lo_sum_q  <= lo_sum_d;
                lo_c_q    <= lo_c_d;
                hi_sum0_q <= hi_sum0_d;
                hi_sum1_q <= hi_sum1_d;
                hi_c0_q   <= hi_c0_d;
                hi_c1_q   <= hi_c1_d;
                a_msb_q   <= A[WIDTH-1];
                b_msb_q   <= b_eff[WIDTH-1];
            end
        end
    end

    // Carry ripples block-by-block through the select muxes only.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        sel_sum            = '0;
        carry              = lo_c_q;
        sel_sum[BLK-1:0]   = lo_sum_q;
        for (int k = 1; k < NBLK; k++) begin
            sel_sum[k*BLK +: BLK] = carry ? hi_sum1_q[k] : hi_sum0_q[k];
            carry                 = carry ? hi_c1_q[k]   : hi_c0_q[k];
        end
        sel_ovf = (a_msb_q == b_msb_q) && (sel_sum[WIDTH-1] != a_msb_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            OutValid <= 1'b0;
            Sum      <= '0;
            Cout     <= 1'b0;
            Ovf      <= 1'b0;
        end else if (ready2) begin
            OutValid <= v1;
            if (v1) begin
                Sum  <= sel_sum;
                Cout <= carry;
                Ovf  <= sel_ovf;
            end
        end
    end

endmodule

// File: tb/tb_carry_select_adder_pipe.sv
// Bench for carry_select_adder_pipe: directed vectors on 16/4, random streams on 16/4, 32/8 and 8/4,
// scored against an integer-arithmetic reference model.
module tb_carry_select_adder_pipe;

    localparam int NR = 10000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  in_valid, in_ready, out_valid, out_ready, cin, sub, cout, ovf;
    logic [31:0] a_in [3];
    logic [31:0] b_in [3];
    logic [15:0] sum16;
    logic [31:0] sum32;
    logic [7:0]  sum8;

    int checks = 0;
    int errors = 0;

    logic [33:0] q0[$];
    logic [33:0] q1[$];
    logic [33:0] q2[$];
    int          rx [3];
    logic        acc [3];
    logic        stall_prev [3];
    logic [33:0] val_prev [3];

    carry_select_adder_pipe #(.WIDTH(16), .BLK(4)) u_dut16 (
        .clk(clk), .rst(rst), .InValid(in_valid[0]), .InReady(in_ready[0]),
        .A(a_in[0][15:0]), .B(b_in[0][15:0]), .Cin(cin[0]), .Sub(sub[0]),
        .OutValid(out_valid[0]), .OutReady(out_ready[0]), .Sum(sum16), .Cout(cout[0]), .Ovf(ovf[0])
    );

    carry_select_adder_pipe #(.WIDTH(32), .BLK(8)) u_dut32 (
        .clk(clk), .rst(rst), .InValid(in_valid[1]), .InReady(in_ready[1]),
        .A(a_in[1]), .B(b_in[1]), .Cin(cin[1]), .Sub(sub[1]),
        .OutValid(out_valid[1]), .OutReady(out_ready[1]), .Sum(sum32), .Cout(cout[1]), .Ovf(ovf[1])
    );

    carry_select_adder_pipe #(.WIDTH(8), .BLK(4)) u_dut8 (
        .clk(clk), .rst(rst), .InValid(in_valid[2]), .InReady(in_ready[2]),
        .A(a_in[2][7:0]), .B(b_in[2][7:0]), .Cin(cin[2]), .Sub(sub[2]),
        .OutValid(out_valid[2]), .OutReady(out_ready[2]), .Sum(sum8), .Cout(cout[2]), .Ovf(ovf[2])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int w_of(input int id);
        case (id)
            0:       return 16;
            1:       return 32;
            default: return 8;
        endcase
    endfunction

    function automatic logic [31:0] get_sum(input int id);
        case (id)
            0:       return {16'd0, sum16};
            1:       return sum32;
            default: return {24'd0, sum8};
        endcase
    endfunction

    // Reference: exact unsigned and signed integer results, then reduce to w bits.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic su);
        longint mask, half, ua, ub, sa, sb, tot, sr;
        logic   co, ov;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'({32'd0, a}) & mask;
        ub   = longint'({32'd0, b}) & mask;
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        if (su) begin
            tot = ua - ub;
            co  = (ua >= ub);
            sr  = sa - sb;
        end else begin
            tot = ua + ub + longint'({63'd0, ci});
            co  = (tot > mask);
            sr  = sa + sb + longint'({63'd0, ci});
        end
        ov = (sr >= half) || (sr < -half);
        return {co, ov, 32'(tot & mask)};
    endfunction

    task automatic push(input int id, input logic [33:0] v);
        case (id)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic pop(input int id, output logic [33:0] v, output bit ok);
        ok = 1'b0;
        v  = '0;
        case (id)
            0:       if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Scoreboard and hold checker, sampled on the falling edge.
    logic [33:0] act_v, exp_v;
    bit          got;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
            for (int i = 0; i < 3; i++) begin
                stall_prev[i] = 1'b0;
                acc[i]        = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                act_v = {cout[i], ovf[i], get_sum(i)};
                if (stall_prev[i])
                    check($sformatf("hold%0d", i), {30'd0, out_valid[i], act_v}, {30'd0, 1'b1, val_prev[i]});
                if (out_valid[i] && out_ready[i]) begin
                    pop(i, exp_v, got);
                    rx[i]++;
                    if (got) check($sformatf("sb%0d", i), {30'd0, act_v}, {30'd0, exp_v});
                    else begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out%0d: got %h want none", i, act_v);
                    end
                end
                if (in_valid[i] && in_ready[i])
                    push(i, model(w_of(i), a_in[i], b_in[i], cin[i], sub[i]));
                acc[i]        = in_valid[i] && in_ready[i];
                stall_prev[i] = out_valid[i] && !out_ready[i];
                val_prev[i]   = act_v;
            end
        end
    end

    task automatic send16(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic su,
                          input logic [15:0] es, input logic ec, input logic eo);
        @(posedge clk); #1;
        in_valid[0] = 1'b1;
        a_in[0] = {16'd0, a};
        b_in[0] = {16'd0, b};
        cin[0] = ci;
        sub[0] = su;
        @(negedge clk);
        check({nm, "_inready"}, in_ready[0], 1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        check({nm, "_early"}, out_valid[0], 0);
        @(negedge clk);
        check({nm, "_valid"}, out_valid[0], 1);
        check({nm, "_sum"}, sum16, es);
        check({nm, "_cout"}, cout[0], ec);
        check({nm, "_ovf"}, ovf[0], eo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    int base;
    int sent [3];
    int rbase [3];
    int t;
    int cyc;

    initial begin
        rst = 1'b1;
        in_valid = '0;
        out_ready = '1;
        cin = '0;
        sub = '0;
        for (int i = 0; i < 3; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
            rx[i] = 0;
            sent[i] = 0;
        end

        #3;
        check("rst_outvalid", out_valid, 0);
        check("rst_sum", sum16, 0);
        check("rst_cout_ovf", {cout[0], ovf[0]}, 0);
        check("rst_inready", in_ready, 0);
        #9 rst = 1'b0;
        @(negedge clk);
        check("post_rst_inready", in_ready, 3'b111);

        send16("add_ff_1",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        send16("add_ffff_c", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        send16("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send16("sub_5_7",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send16("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send16("sub_cin",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send16("add_mix",    16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Six back-to-back beats with a three-cycle output stall after the first result.
        @(posedge clk); #1;
        base = rx[0];
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int tt;
                    in_valid[0] = 1'b1;
                    a_in[0] = 32'(32'h1111 * (i + 1));
                    b_in[0] = 32'(32'h0F0F + i);
                    cin[0] = 1'b0;
                    sub[0] = i[0];
                    tt = 0;
                    do begin @(negedge clk); tt++; end while (!in_ready[0] && tt < 20);
                    check("stream_accept", in_ready[0], 1);
                    @(posedge clk); #1;
                end
                in_valid[0] = 1'b0;
            end
            begin
                int tt;
                tt = 0;
                do begin @(posedge clk); #1; tt++; end while (!out_valid[0] && tt < 20);
                check("stream_first_out", out_valid[0], 1);
                out_ready[0] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_inready", in_ready[0], 0);
                    @(posedge clk);
                end
                #1 out_ready[0] = 1'b1;
            end
        join
        t = 0;
        while (rx[0] - base < 6 && t < 30) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        check("stream_count", rx[0] - base, 6);
        check("stream_q_empty", q0.size(), 0);

        // Reset between edges with two beats in flight.
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b1;
        a_in[0] = 32'h1234;
        b_in[0] = 32'h1111;
        sub[0] = 1'b0;
        cin[0] = 1'b0;
        @(posedge clk); #1;
        a_in[0] = 32'h2222;
        b_in[0] = 32'h0101;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("inflight_outvalid", out_valid[0], 1);
        check("inflight_inready", in_ready[0], 0);
        check("inflight_sum", sum16, 16'h2345);
        #1 rst = 1'b1;
        #1;
        check("async_outvalid", out_valid[0], 0);
        check("async_sum", sum16, 0);
        check("async_inready", in_ready[0], 0);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("rel_inready", in_ready[0], 1);
        repeat (3) begin
            check("no_stale", out_valid[0], 0);
            @(negedge clk);
        end
        send16("post_rst", 16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0);

        // Random traffic on all three widths.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            sent[i] = 0;
            rbase[i] = rx[i];
        end
        cyc = 0;
        while ((sent[0] < NR || sent[1] < NR || sent[2] < NR) && cyc < 40000) begin
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) sent[i]++;
                if (!(in_valid[i] && !acc[i])) begin
                    if (sent[i] < NR) begin
                        in_valid[i] = ($urandom_range(0, 3) != 0);
                        a_in[i] = $urandom;
                        b_in[i] = $urandom;
                        cin[i] = 1'($urandom_range(0, 1));
                        sub[i] = 1'($urandom_range(0, 1));
                    end else begin
                        in_valid[i] = 1'b0;
                    end
                end
                out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = '0;
        out_ready = '1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rand_sent%0d", i), sent[i], NR);
            check($sformatf("rand_rx%0d", i), rx[i] - rbase[i], NR);
        end
        check("rand_q_empty", q0.size() + q1.size() + q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
